// File: rtl/pred_block_sequencer.sv
// Raster block scheduler: mode -> (inter: ref fetch) -> predictor launch -> valid/ready emit; >=4 cycles/block + predictor latency, inter +2.
// Holds in EMIT while out_ready is low; `define PRED_SEQ_TIMEOUT_EN to bound WAIT_PRED to PRED_TIMEOUT cycles after launch.
module pred_block_sequencer #(
   parameter int BLOCK_SIZE    = 8,
   parameter int MAX_BLKS_LOG2 = 7,
   parameter int PRED_TIMEOUT  = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [MAX_BLKS_LOG2-1:0] frame_w_blks,
   input  logic [MAX_BLKS_LOG2-1:0] frame_h_blks,
   input  logic                     mode_valid,
   output logic                     mode_ready,
   input  logic [7:0]               mode_pred,
   input  logic [7:0]               mode_intra,
   input  logic signed [8:0]        mode_mv_x,
   input  logic signed [8:0]        mode_mv_y,
   output logic                     ref_req,
   input  logic                     ref_ack,
   output logic [9:0]               ref_x,
   output logic [9:0]               ref_y,
   output logic                     pred_start,
   output logic [7:0]               pred_mode,
   output logic [7:0]               intra_mode,
   output logic signed [8:0]        mv_x,
   output logic signed [8:0]        mv_y,
   output logic [9:0]               pos_x,
   output logic [9:0]               pos_y,
   output logic                     top_available,
   output logic                     left_available,
   input  logic                     pred_valid,
   input  logic                     pred_error,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_error,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              err_count
);

   localparam int BS_LOG2 = $clog2(BLOCK_SIZE);
   localparam logic [MAX_BLKS_LOG2-1:0] BLK_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE, S_GET_MODE, S_FETCH_REF, S_LAUNCH, S_WAIT_PRED, S_EMIT
   } state_t;

   state_t                   r_state;
   logic [MAX_BLKS_LOG2-1:0] r_frame_w, r_frame_h, r_blk_x, r_blk_y;
   logic                     r_mode_ready, r_ref_req, r_pred_start;
   logic [9:0]               r_ref_x, r_ref_y;
   logic [7:0]               r_pred_mode, r_intra_mode;
   logic signed [8:0]        r_mv_x, r_mv_y;
   logic                     r_out_valid, r_out_error, r_out_last, r_done;
   logic [15:0]              r_err_count;

   logic [9:0]               w_pos_x, w_pos_y;
   logic [11:0]              w_fw_px, w_fh_px;
   logic signed [11:0]       w_sum_x, w_sum_y, w_max_x, w_max_y;
   logic [9:0]               w_ref_x, w_ref_y;
   logic                     w_x_wrap, w_is_last;

   assign w_pos_x = 10'(r_blk_x) << BS_LOG2;
   assign w_pos_y = 10'(r_blk_y) << BS_LOG2;

   // Window origin: block origin + MV, clamped so the whole window lies inside the frame.
   assign w_sum_x = $signed({2'b00, w_pos_x}) + $signed({{3{r_mv_x[8]}}, r_mv_x});
   assign w_sum_y = $signed({2'b00, w_pos_y}) + $signed({{3{r_mv_y[8]}}, r_mv_y});
   assign w_fw_px = 12'(r_frame_w) << BS_LOG2;
   assign w_fh_px = 12'(r_frame_h) << BS_LOG2;
   assign w_max_x = $signed(w_fw_px) - 12'(BLOCK_SIZE);
   assign w_max_y = $signed(w_fh_px) - 12'(BLOCK_SIZE);

   always_comb begin
      w_ref_x = w_sum_x[9:0];
      if (w_sum_x < 0)
         w_ref_x = '0;
      else if (w_sum_x > w_max_x)
         w_ref_x = w_max_x[9:0];
      w_ref_y = w_sum_y[9:0];
      if (w_sum_y < 0)
         w_ref_y = '0;
      else if (w_sum_y > w_max_y)
         w_ref_y = w_max_y[9:0];
   end

   assign w_x_wrap  = (r_blk_x == r_frame_w - BLK_ONE);
   assign w_is_last = w_x_wrap && (r_blk_y == r_frame_h - BLK_ONE);

`ifdef PRED_SEQ_TIMEOUT_EN
   logic [15:0] r_to_cnt;
   logic        w_timeout;
   // r_to_cnt counts cycles since LAUNCH, so EMIT starts exactly PRED_TIMEOUT cycles after it.
   assign w_timeout = ((r_to_cnt + 16'd1) == 16'(PRED_TIMEOUT));
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_frame_w    <= '0;
         r_frame_h    <= '0;
         r_blk_x      <= '0;
         r_blk_y      <= '0;
         r_mode_ready <= 1'b0;
         r_ref_req    <= 1'b0;
         r_ref_x      <= '0;
         r_ref_y      <= '0;
         r_pred_start <= 1'b0;
         r_pred_mode  <= '0;
         r_intra_mode <= '0;
         r_mv_x       <= '0;
         r_mv_y       <= '0;
         r_out_valid  <= 1'b0;
         r_out_error  <= 1'b0;
         r_out_last   <= 1'b0;
         r_done       <= 1'b0;
         r_err_count  <= '0;
`ifdef PRED_SEQ_TIMEOUT_EN
         r_to_cnt     <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_frame_w   <= frame_w_blks;
                  r_frame_h   <= frame_h_blks;
                  r_blk_x     <= '0;
                  r_blk_y     <= '0;
                  r_err_count <= '0;
                  if (frame_w_blks == '0 || frame_h_blks == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_mode_ready <= 1'b1;
                     r_state      <= S_GET_MODE;
                  end
               end
            end
            S_GET_MODE: begin
               if (mode_valid) begin
                  r_mode_ready <= 1'b0;
                  r_pred_mode  <= mode_pred;
                  r_intra_mode <= mode_intra;
                  r_mv_x       <= mode_mv_x;
                  r_mv_y       <= mode_mv_y;
                  if (mode_pred == 8'h01) begin
                     r_state <= S_FETCH_REF;
                  end else begin
                     r_pred_start <= 1'b1;
                     r_state      <= S_LAUNCH;
                  end
               end
            end
            S_FETCH_REF: begin
               // Entry cycle registers the clamped origin so it is stable for the whole request.
               if (!r_ref_req) begin
                  r_ref_req <= 1'b1;
                  r_ref_x   <= w_ref_x;
                  r_ref_y   <= w_ref_y;
               end else if (ref_ack) begin
                  r_ref_req    <= 1'b0;
                  r_pred_start <= 1'b1;
                  r_state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_pred_start <= 1'b0;
               r_state      <= S_WAIT_PRED;
`ifdef PRED_SEQ_TIMEOUT_EN
               r_to_cnt     <= 16'd1;
`endif
            end
            S_WAIT_PRED: begin
               if (pred_valid) begin
                  r_out_error <= pred_error;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_is_last;
                  r_state     <= S_EMIT;
               end
`ifdef PRED_SEQ_TIMEOUT_EN
               else if (w_timeout) begin
                  r_out_error <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_is_last;
                  r_state     <= S_EMIT;
               end else begin
                  r_to_cnt <= r_to_cnt + 16'd1;
               end
`endif
            end
            S_EMIT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_error <= 1'b0;
                  r_out_last  <= 1'b0;
                  if (r_out_error && r_err_count != 16'hFFFF)
                     r_err_count <= r_err_count + 16'd1;
                  if (r_out_last) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     if (w_x_wrap) begin
                        r_blk_x <= '0;
                        r_blk_y <= r_blk_y + BLK_ONE;
                     end else begin
                        r_blk_x <= r_blk_x + BLK_ONE;
                     end
                     r_mode_ready <= 1'b1;
                     r_state      <= S_GET_MODE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mode_ready     = r_mode_ready;
   assign ref_req        = r_ref_req;
   assign ref_x          = r_ref_x;
   assign ref_y          = r_ref_y;
   assign pred_start     = r_pred_start;
   assign pred_mode      = r_pred_mode;
   assign intra_mode     = r_intra_mode;
   assign mv_x           = r_mv_x;
   assign mv_y           = r_mv_y;
   assign pos_x          = w_pos_x;
   assign pos_y          = w_pos_y;
   assign top_available  = (r_blk_y != '0);
   assign left_available = (r_blk_x != '0);
   assign out_valid      = r_out_valid;
   assign out_error      = r_out_error;
   assign out_last       = r_out_last;
   assign busy           = (r_state != S_IDLE);
   assign done           = r_done;
   assign err_count      = r_err_count;

endmodule

// File: tb/tb_pred_block_sequencer.sv
// Scoreboard bench for pred_block_sequencer: behavioural mode source, reference fetcher and predictor
// around the DUT; expected block records are queued at stimulus time and popped on each output handshake.
module tb_pred_block_sequencer;

   logic              clk = 1'b0;
   logic              reset_n, start;
   logic [6:0]        frame_w_blks, frame_h_blks;
   logic              mode_valid, mode_ready;
   logic [7:0]        mode_pred, mode_intra;
   logic signed [8:0] mode_mv_x, mode_mv_y;
   logic              ref_req, ref_ack;
   logic [9:0]        ref_x, ref_y;
   logic              pred_start;
   logic [7:0]        pred_mode, intra_mode;
   logic signed [8:0] mv_x, mv_y;
   logic [9:0]        pos_x, pos_y;
   logic              top_available, left_available;
   logic              pred_valid, pred_error;
   logic              out_valid, out_ready, out_error, out_last, busy, done;
   logic [15:0]       err_count;

   pred_block_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .frame_w_blks(frame_w_blks), .frame_h_blks(frame_h_blks),
      .mode_valid(mode_valid), .mode_ready(mode_ready), .mode_pred(mode_pred),
      .mode_intra(mode_intra), .mode_mv_x(mode_mv_x), .mode_mv_y(mode_mv_y),
      .ref_req(ref_req), .ref_ack(ref_ack), .ref_x(ref_x), .ref_y(ref_y),
      .pred_start(pred_start), .pred_mode(pred_mode), .intra_mode(intra_mode),
      .mv_x(mv_x), .mv_y(mv_y), .pos_x(pos_x), .pos_y(pos_y),
      .top_available(top_available), .left_available(left_available),
      .pred_valid(pred_valid), .pred_error(pred_error),
      .out_valid(out_valid), .out_ready(out_ready), .out_error(out_error),
      .out_last(out_last), .busy(busy), .done(done), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] pred; logic [7:0] intra; logic signed [8:0] mvx; logic signed [8:0] mvy; } mode_rec_t;
   typedef struct { logic [9:0] px; logic [9:0] py; logic top; logic left; logic err; logic last;
                    logic [7:0] pred; logic [7:0] intra; logic signed [8:0] mvx; } exp_rec_t;
   typedef struct { logic [9:0] rx; logic [9:0] ry; } ref_rec_t;

   mode_rec_t mode_q[$];
   logic      perr_q[$];
   exp_rec_t  exp_q[$];
   ref_rec_t  ref_q[$];

   int n_chk = 0, n_err = 0;
   int n_done = 0, n_pstart = 0, cyc = 0;
   int pred_lat = 1, ref_delay = 5, stall = 0;
   bit pred_en = 1'b1;
   int t_launch = 0, t_emit = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctrl"}, {mode_ready, ref_req, pred_start, out_valid, out_error, out_last,
                           busy, done, top_available, left_available}, 32'd0);
      chk({tag, "_pos"}, {pos_x, pos_y}, 32'd0);
      chk({tag, "_ref"}, {ref_x, ref_y}, 32'd0);
      chk({tag, "_mode"}, {pred_mode, intra_mode}, 32'd0);
      chk({tag, "_mv"}, {mv_x, mv_y}, 32'd0);
      chk({tag, "_errcnt"}, err_count, 32'd0);
   endtask

   // Mode source: presents the queue head, pops after each accepted handshake.
   initial begin
      bit hs_mode;
      mode_valid = 0; mode_pred = 0; mode_intra = 0; mode_mv_x = 0; mode_mv_y = 0;
      forever begin
         @(negedge clk);
         hs_mode = mode_valid && mode_ready;
         @(posedge clk); #1;
         if (hs_mode && mode_q.size() > 0) mode_q.delete(0);
         if (mode_q.size() > 0) begin
            mode_valid = 1'b1;
            mode_pred  = mode_q[0].pred;
            mode_intra = mode_q[0].intra;
            mode_mv_x  = mode_q[0].mvx;
            mode_mv_y  = mode_q[0].mvy;
         end else begin
            mode_valid = 1'b0;
         end
      end
   end

   // Predictor: answers each launch after pred_lat cycles with the queued error bit.
   initial begin
      logic e;
      pred_valid = 0; pred_error = 0;
      forever begin
         @(negedge clk);
         if (pred_start && pred_en) begin
            e = 1'b0;
            if (perr_q.size() > 0) e = perr_q.pop_front();
            repeat (pred_lat) @(posedge clk);
            #1 pred_valid = 1'b1; pred_error = e;
            @(posedge clk);
            #1 pred_valid = 1'b0; pred_error = 1'b0;
         end
      end
   end

   // Reference fetcher: checks the window origin and that the request holds until acked.
   initial begin
      ref_rec_t   r;
      logic [9:0] hx, hy;
      bit         ab;
      ref_ack = 0;
      forever begin
         @(negedge clk);
         if (ref_req && reset_n) begin
            chk("ref_expected", ref_q.size() > 0, 1);
            r.rx = 10'h3FF; r.ry = 10'h3FF;
            if (ref_q.size() > 0) r = ref_q.pop_front();
            chk("ref_x", ref_x, r.rx);
            chk("ref_y", ref_y, r.ry);
            hx = ref_x; hy = ref_y; ab = 0;
            for (int i = 0; i < ref_delay - 1; i++) begin
               @(negedge clk);
               if (!reset_n) begin ab = 1; break; end
               chk("ref_req_held", {ref_req, ref_x, ref_y}, {1'b1, hx, hy});
            end
            if (!ab) begin
               @(posedge clk); #1 ref_ack = 1'b1;
               @(posedge clk); #1 ref_ack = 1'b0;
               @(negedge clk);
               chk("ref_req_drop", ref_req, 0);
            end
         end
      end
   end

   // Downstream: holds out_ready low for 'stall' EMIT cycles, otherwise ready.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (out_valid && stall > 0) begin
            out_ready = 1'b0;
            stall--;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on each output handshake, checks hold behaviour in EMIT.
   initial begin
      logic       ov_prev;
      logic [9:0] s_px, s_py;
      logic       s_err, s_last;
      exp_rec_t   e;
      ov_prev = 0; s_px = 0; s_py = 0; s_err = 0; s_last = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (pred_start) begin n_pstart++; t_launch = cyc; end
         if (done) n_done++;
         if (out_valid) begin
            if (!ov_prev) t_emit = cyc;
            else chk("emit_stable", {out_error, out_last, pos_x, pos_y}, {s_err, s_last, s_px, s_py});
            chk("emit_quiet", {mode_ready, pred_start, ref_req}, 3'b000);
            s_err = out_error; s_last = out_last; s_px = pos_x; s_py = pos_y;
            if (out_ready) begin
               chk("block_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("pos_x", pos_x, e.px);
                  chk("pos_y", pos_y, e.py);
                  chk("top_left", {top_available, left_available}, {e.top, e.left});
                  chk("out_error", out_error, e.err);
                  chk("out_last", out_last, e.last);
                  chk("pred_mode", pred_mode, e.pred);
                  chk("intra_mode", intra_mode, e.intra);
                  chk("mv_x", mv_x, e.mvx);
               end
            end
         end
         ov_prev = out_valid;
      end
   end

   task automatic push_block(input int bx, input int by, input int w, input int h,
                             input logic [7:0] pred, input logic signed [8:0] mx,
                             input logic signed [8:0] my, input logic perr,
                             input int rx, input int ry);
      mode_rec_t m;
      exp_rec_t  e;
      ref_rec_t  r;
      m.pred = pred; m.intra = 8'(by * 16 + bx); m.mvx = mx; m.mvy = my;
      mode_q.push_back(m);
      perr_q.push_back(perr);
      e.px = 10'(bx * 8); e.py = 10'(by * 8);
      e.top = (by != 0); e.left = (bx != 0);
      e.err = perr; e.last = (bx == w - 1) && (by == h - 1);
      e.pred = pred; e.intra = m.intra; e.mvx = mx;
      exp_q.push_back(e);
      if (pred == 8'h01) begin
         r.rx = 10'(rx); r.ry = 10'(ry);
         ref_q.push_back(r);
      end
   endtask

   task automatic fill_intra(input int w, input int h);
      for (int by = 0; by < h; by++)
         for (int bx = 0; bx < w; bx++)
            push_block(bx, by, w, h, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
   endtask

   task automatic start_frame(input int w, input int h);
      @(posedge clk); #1;
      frame_w_blks = 7'(w); frame_h_blks = 7'(h); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input string name, input int w, input int h, input int exp_errs);
      int d0, p0, t;
      d0 = n_done; p0 = n_pstart; t = 0;
      start_frame(w, h);
      while (n_done == d0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk({name, "_done_once"}, n_done - d0, 1);
      chk({name, "_pred_starts"}, n_pstart - p0, w * h);
      chk({name, "_err_count"}, err_count, exp_errs);
      chk({name, "_idle"}, busy, 0);
      chk({name, "_drained"}, exp_q.size() + ref_q.size() + mode_q.size(), 0);
      perr_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, t;
      reset_n = 1'b0; start = 1'b0; frame_w_blks = 0; frame_h_blks = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Zero-sized frame: immediate done, never busy.
      d0 = n_done;
      start_frame(0, 3);
      @(negedge clk);
      chk("zero_dim_done", done, 1);
      chk("zero_dim_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("zero_dim_once", n_done - d0, 1);

      // 2x2 all intra.
      fill_intra(2, 2);
      run_frame("intra2x2", 2, 2, 0);

      // 1x1 inter, negative MV clamps to origin.
      push_block(0, 0, 1, 1, 8'h01, -9'sd5, -9'sd3, 1'b0, 0, 0);
      run_frame("inter1x1", 1, 1, 0);

      // 4x4 with three inter blocks: (8,8)+(-5,3), (0,24)+(-5,100), (24,24)+(20,0).
      for (int i = 0; i < 16; i++) begin
         if (i == 5)       push_block(1, 1, 4, 4, 8'h01, -9'sd5, 9'sd3, 1'b0, 3, 11);
         else if (i == 12) push_block(0, 3, 4, 4, 8'h01, -9'sd5, 9'sd100, 1'b0, 0, 24);
         else if (i == 15) push_block(3, 3, 4, 4, 8'h01, 9'sd20, 9'sd0, 1'b0, 24, 24);
         else              push_block(i % 4, i / 4, 4, 4, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      end
      run_frame("inter4x4", 4, 4, 0);

      // Invalid mode reported as an error by a slower predictor.
      pred_lat = 3;
      push_block(0, 0, 2, 1, 8'h07, 9'sd0, 9'sd0, 1'b1, 0, 0);
      push_block(1, 0, 2, 1, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      run_frame("badmode", 2, 1, 1);
      pred_lat = 1;

      // Downstream stall of 10 cycles on an errored block.
      stall = 10;
      push_block(0, 0, 1, 2, 8'h00, 9'sd0, 9'sd0, 1'b1, 0, 0);
      push_block(0, 1, 1, 2, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      run_frame("stall", 1, 2, 1);
      chk("stall_used", stall, 0);

      // Reset while the third block is fetching its reference.
      ref_delay = 20;
      push_block(0, 0, 2, 2, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      push_block(1, 0, 2, 2, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      push_block(0, 1, 2, 2, 8'h01, 9'sd0, 9'sd0, 1'b0, 0, 8);
      push_block(1, 1, 2, 2, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      d0 = n_done;
      start_frame(2, 2);
      t = 0;
      while (!ref_req && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("midrst_ref_req_seen", ref_req, 1);
      @(posedge clk); #1 reset_n = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      mode_q.delete(); perr_q.delete(); exp_q.delete(); ref_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_no_done", n_done - d0, 0);
      ref_delay = 5;
      push_block(0, 0, 2, 2, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      push_block(1, 0, 2, 2, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      push_block(0, 1, 2, 2, 8'h00, 9'sd0, 9'sd0, 1'b0, 0, 0);
      push_block(1, 1, 2, 2, 8'h01, 9'sd3, -9'sd20, 1'b0, 8, 0);
      run_frame("after_rst", 2, 2, 0);

`ifdef PRED_SEQ_TIMEOUT_EN
      // Silent predictor: EMIT forced 32 cycles after LAUNCH with an error.
      pred_en = 1'b0;
      push_block(0, 0, 1, 1, 8'h00, 9'sd0, 9'sd0, 1'b1, 0, 0);
      run_frame("timeout", 1, 1, 1);
      chk("timeout_latency", t_emit - t_launch, 32);
      pred_en = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
